jt12_eg_sched: RTL and testbench



---
 rtl/jt12_eg_pkg.sv | 24 ++
 rtl/jt12_eg_inc.sv | 41 ++++
 rtl/jt12_eg_sched.sv | 116 +++++++++++
 tb/tb_jt12_eg_sched.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/jt12_eg_pkg.sv
// Shared constants for the envelope step scheduler: slot count, increment row tables, rate thresholds.
// The rows are written MSB-first, so idx 0 is the leftmost character of each string.
package jt12_eg_pkg;

    localparam int EG_SLOTS = 24;

    localparam logic [7:0] EG_L0 = 8'b01010101;
    localparam logic [7:0] EG_L1 = 8'b01010111;
    localparam logic [7:0] EG_L2 = 8'b01110111;
    localparam logic [7:0] EG_L3 = 8'b01111111;

    localparam logic [7:0] EG_H0 = 8'b00000000;
    localparam logic [7:0] EG_H1 = 8'b00010001;
    localparam logic [7:0] EG_H2 = 8'b01010101;
    localparam logic [7:0] EG_H3 = 8'b01110111;

    localparam logic [5:0] RATE_FAST = 6'd48;
    localparam logic [5:0] RATE_MAX  = 6'd60;

    function automatic logic eg_row_bit(input logic [7:0] row, input logic [2:0] idx);
        return row[3'd7 - idx];
    endfunction

endpackage

// File: rtl/jt12_eg_inc.sv
// Combinational (rate, idx) -> attenuation increment lookup; zero latency, no state.
// Shared between the normal envelope path and the SSG-EG path.
module jt12_eg_inc
    import jt12_eg_pkg::*;
(
    input  logic [5:0] i_rate,
    input  logic [2:0] i_idx,
    output logic [3:0] o_inc
);

    logic [7:0] w_lrow;
    logic [7:0] w_hrow;
    logic       w_lbit;
    logic       w_hbit;
    logic [3:0] w_base;

    always_comb begin
        w_lrow = EG_L0;
        w_hrow = EG_H0;
        case (i_rate[1:0])
            2'd0: begin w_lrow = EG_L0; w_hrow = EG_H0; end
            2'd1: begin w_lrow = EG_L1; w_hrow = EG_H1; end
            2'd2: begin w_lrow = EG_L2; w_hrow = EG_H2; end
            default: begin w_lrow = EG_L3; w_hrow = EG_H3; end
        endcase
        w_lbit = eg_row_bit(w_lrow, i_idx);
        w_hbit = eg_row_bit(w_hrow, i_idx);
        // fast rates 48..59 have rate[5:2] in 12..14, giving base 1, 2 or 4
        w_base = 4'd1 << 2'(i_rate[5:2] - 4'd12);

        o_inc = 4'd0;
        if (i_rate >= RATE_MAX) begin
            o_inc = 4'd8;
        end else if (i_rate >= RATE_FAST) begin
            o_inc = w_base << w_hbit;
        end else if (i_rate >= 6'd2) begin
            o_inc = {3'b000, w_lbit};
        end
    end

endmodule

// File: rtl/jt12_eg_sched.sv
// Envelope step scheduler: slot sequencer, per-pass change detect and a 2-stage step decision pipeline.
// Step result for slot N appears 2 clk_en pulses after its rate is sampled; everything holds while clk_en is low.
module jt12_eg_sched
    import jt12_eg_pkg::*;
#(
    parameter int SLOTS = EG_SLOTS,
    parameter int CNTW  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic [CNTW-1:0] eg_cnt,
    input  logic [5:0]      rate,
    output logic [4:0]      slot,
    output logic            zero,
    output logic            step_en,
    output logic [3:0]      step_inc,
    output logic [4:0]      step_slot
);

    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [4:0]      SLOT_TOP = 5'(SLOTS - 1);

    logic [4:0]      r_slot;
    logic [CNTW-1:0] r_prev_cnt;
    logic            r_pass_active;

    logic            r_s1_vld;
    logic [4:0]      r_s1_slot;
    logic [5:0]      r_s1_rate;
    logic [CNTW-1:0] r_s1_cnt;

    logic            r_step_en;
    logic [3:0]      r_step_inc;
    logic [4:0]      r_step_slot;

    logic            w_slot0;
    logic            w_new_pass;
    logic            w_s1_vld;
    logic [3:0]      w_shift;
    logic [CNTW-1:0] w_mask;
    logic            w_fast;
    logic            w_hit;
    logic [2:0]      w_idx;
    logic [3:0]      w_inc;
    logic            w_step;

    assign w_slot0 = (r_slot == 5'd0);
    // any difference, including the 0x7FFF -> 0 wrap, marks the counter as having ticked
    assign w_new_pass = (eg_cnt != r_prev_cnt);
    assign w_s1_vld   = w_slot0 ? w_new_pass : r_pass_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot        <= 5'd0;
            r_prev_cnt    <= '0;
            r_pass_active <= 1'b0;
        end else if (clk_en) begin
            r_slot <= (r_slot == SLOT_TOP) ? 5'd0 : r_slot + 5'd1;
            if (w_slot0) begin
                r_pass_active <= w_new_pass;
                r_prev_cnt    <= eg_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_slot <= 5'd0;
            r_s1_rate <= 6'd0;
            r_s1_cnt  <= '0;
        end else if (clk_en) begin
            r_s1_vld  <= w_s1_vld;
            r_s1_slot <= r_slot;
            r_s1_rate <= rate;
            r_s1_cnt  <= eg_cnt;
        end
    end

    // w_shift is only meaningful below RATE_FAST, where rate[5:2] <= 11
    always_comb begin
        w_fast  = (r_s1_rate >= RATE_FAST);
        w_shift = 4'd11 - r_s1_rate[5:2];
        w_mask  = (CNT_ONE << w_shift) - CNT_ONE;
        w_hit   = w_fast || ((r_s1_cnt & w_mask) == '0);
        w_idx   = w_fast ? r_s1_cnt[2:0] : 3'(r_s1_cnt >> w_shift);
    end

    jt12_eg_inc u_inc (
        .i_rate (r_s1_rate),
        .i_idx  (w_idx),
        .o_inc  (w_inc)
    );

    assign w_step = r_s1_vld && w_hit && (w_inc != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_en   <= 1'b0;
            r_step_inc  <= 4'd0;
            r_step_slot <= 5'd0;
        end else if (clk_en) begin
            r_step_en   <= w_step;
            r_step_inc  <= w_step ? w_inc : 4'd0;
            r_step_slot <= r_s1_slot;
        end
    end

    assign slot      = r_slot;
    assign zero      = w_slot0;
    assign step_en   = r_step_en;
    assign step_inc  = r_step_inc;
    assign step_slot = r_step_slot;

endmodule

// File: tb/tb_jt12_eg_sched.sv
// Directed-vector bench for jt12_eg_sched with hand-computed expectations.
module tb_jt12_eg_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [14:0] eg_cnt;
    logic [5:0]  rate;
    logic [4:0]  slot;
    logic        zero;
    logic        step_en;
    logic [3:0]  step_inc;
    logic [4:0]  step_slot;

    int n_vec = 0;
    int n_err = 0;

    jt12_eg_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .eg_cnt    (eg_cnt),
        .rate      (rate),
        .slot      (slot),
        .zero      (zero),
        .step_en   (step_en),
        .step_inc  (step_inc),
        .step_slot (step_slot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        clk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic to_slot0();
        int guard = 0;
        while (slot != 5'd0 && guard < 30) begin
            tick();
            guard++;
        end
        check("sync_slot0", 32'(slot), 32'd0);
    endtask

    // One full pass: set counter and rate at slot 0, then expect 24 identical step results
    task automatic run_pass(input string tag, input logic [14:0] cnt, input logic [5:0] rt,
                            input logic exp_en, input logic [3:0] exp_inc);
        to_slot0();
        eg_cnt = cnt;
        rate   = rt;
        for (int j = 0; j < 25; j++) begin
            tick();
            if (j >= 1) begin
                check($sformatf("%s_slot%0d", tag, j - 1), 32'(step_slot), 32'(j - 1));
                check($sformatf("%s_en%0d", tag, j - 1), 32'(step_en), 32'(exp_en));
                check($sformatf("%s_inc%0d", tag, j - 1), 32'(step_inc), 32'(exp_inc));
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_en = 1'b0;
        eg_cnt = 15'd0;
        rate   = 6'd0;
        #12;
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_en", 32'(step_en), 32'd0);
        check("rst_inc", 32'(step_inc), 32'd0);
        check("rst_sslot", 32'(step_slot), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequencer over two passes with a static counter
        for (int i = 1; i <= 48; i++) begin
            tick();
            check($sformatf("seq_slot%0d", i), 32'(slot), 32'(i % 24));
            check($sformatf("seq_zero%0d", i), 32'(zero), 32'((i % 24) == 0));
            check($sformatf("seq_en%0d", i), 32'(step_en), 32'd0);
        end

        // clk_en low freezes everything
        clk_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_slot", 32'(slot), 32'd0);
        check("hold_zero", 32'(zero), 32'd1);

        run_pass("r63", 15'h0001, 6'd63, 1'b1, 4'd8);
        run_pass("same", 15'h0001, 6'd63, 1'b0, 4'd0);

        // rate 4: shift 10, row L0
        run_pass("r4_400", 15'h0400, 6'd4, 1'b1, 4'd1);
        run_pass("r4_401", 15'h0401, 6'd4, 1'b0, 4'd0);
        run_pass("r4_800", 15'h0800, 6'd4, 1'b0, 4'd0);

        // rate 50: row H2, base 1
        for (int k = 0; k < 8; k++)
            run_pass($sformatf("r50_c%0d", k), 15'(k), 6'd50, 1'b1, (k % 2 == 1) ? 4'd2 : 4'd1);

        run_pass("wrap_hi", 15'h7FFF, 6'd63, 1'b1, 4'd8);
        run_pass("wrap_lo", 15'h0000, 6'd63, 1'b1, 4'd8);

        // Reset mid-pass with active entries in flight
        to_slot0();
        eg_cnt = 15'h0001;
        rate   = 6'd63;
        repeat (12) tick();
        check("mid_slot", 32'(slot), 32'd12);
        check("mid_en", 32'(step_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_slot", 32'(slot), 32'd0);
        check("arst_zero", 32'(zero), 32'd1);
        check("arst_en", 32'(step_en), 32'd0);
        check("arst_inc", 32'(step_inc), 32'd0);
        check("arst_sslot", 32'(step_slot), 32'd0);
        clk_en = 1'b0;
        eg_cnt = 15'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_slot", 32'(slot), 32'd0);
        check("rel_zero", 32'(zero), 32'd1);
        for (int i = 1; i <= 30; i++) begin
            tick();
            check($sformatf("post_en%0d", i), 32'(step_en), 32'd0);
            check($sformatf("post_slot%0d", i), 32'(slot), 32'(i % 24));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
